// File: rtl/gcd_fsm_if.sv
// gcd_fsm_if: start/busy/done handshake bundle for the gcd_fsm engine.
//   start  : request, honoured only while the engine is idle
//   a, b   : operands, captured on the accepting edge
//   busy   : engine is iterating
//   done   : one-cycle completion pulse
//   result : gcd of the last completed operation
//   iter_count (only with GCD_ITER_COUNT_EN) : subtraction cycles used
// master = requester (controller / bench), slave = gcd_fsm.
interface gcd_fsm_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
`ifdef GCD_ITER_COUNT_EN
  logic [15:0]      iter_count;

  modport master (output start, a, b, input busy, done, result, iter_count);
  modport slave  (input start, a, b, output busy, done, result, iter_count);
`else
  modport master (output start, a, b, input busy, done, result);
  modport slave  (input start, a, b, output busy, done, result);
`endif
endinterface

// File: rtl/gcd_fsm.sv
// gcd_fsm: multicycle subtractive-Euclid GCD engine, one subtraction per
// iteration, with a start/busy/done handshake.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : gcd_fsm_if.slave (start, a, b in; busy, done, result out)
// Optional build macro GCD_ITER_COUNT_EN adds bus.iter_count, a 16-bit
// saturating count of the subtraction cycles in the current/last operation.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// CHECK | compare x and y, finish or pick a subtraction
// SUB_A | x <= x - y
// SUB_B | y <= y - x
// DONE  | done pulse, start ignored
module gcd_fsm #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  gcd_fsm_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0000,
    CHECK = 4'b0001,
    SUB_A = 4'b0010,
    SUB_B = 4'b0011,
    DONE  = 4'b0100
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] x, y, res;
  logic [WIDTH-1:0] x_nxt, y_nxt, res_nxt;
  logic             busy_q, done_q;

  always_comb begin
    state_nxt = IDLE;
    x_nxt     = x;
    y_nxt     = y;
    res_nxt   = res;
    case (state)
      IDLE: begin
        if (bus.start) begin
          x_nxt     = bus.a;
          y_nxt     = bus.b;
          state_nxt = CHECK;
        end else begin
          state_nxt = IDLE;
        end
      end
      CHECK: begin
        if (x == '0) begin
          res_nxt   = y;
          state_nxt = DONE;
        end else if (y == '0) begin
          res_nxt   = x;
          state_nxt = DONE;
        end else if (x == y) begin
          res_nxt   = x;
          state_nxt = DONE;
        end else if (x > y) begin
          state_nxt = SUB_A;
        end else begin
          state_nxt = SUB_B;
        end
      end
      SUB_A: begin
        x_nxt     = x - y;
        state_nxt = CHECK;
      end
      SUB_B: begin
        y_nxt     = y - x;
        state_nxt = CHECK;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are decoded from the next state so the registered flags
  // line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      x      <= '0;
      y      <= '0;
      res    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      x      <= x_nxt;
      y      <= y_nxt;
      res    <= res_nxt;
      busy_q <= (state_nxt == CHECK) || (state_nxt == SUB_A) || (state_nxt == SUB_B);
      done_q <= (state_nxt == DONE);
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = res;

`ifdef GCD_ITER_COUNT_EN
  logic [15:0] iter_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      iter_cnt <= 16'd0;
    end else if (state == IDLE && bus.start) begin
      iter_cnt <= 16'd0;
    end else if ((state == SUB_A || state == SUB_B) && iter_cnt != 16'hFFFF) begin
      iter_cnt <= iter_cnt + 16'd1;
    end
  end

  assign bus.iter_count = iter_cnt;
`endif

endmodule

// File: doc/gcd_fsm.md
Name: gcd_fsm

Overview:
- Multicycle greatest-common-divisor engine using subtractive Euclid, one subtraction per iteration.
- Companion to the LCM engine in the arithmetic exercises: it supplies the gcd(a,b) term, since lcm = a*b/gcd.
- Uses a start/busy/done handshake so a controller or testbench can sequence operations back-to-back.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; latched on the accepting edge.
- b  input  WIDTH  operand B; latched on the accepting edge.
- busy  output  1  high in CHECK, SUB_A and SUB_B.
- done  output  1  one-cycle pulse while in DONE.
- result  output  WIDTH  gcd of the latched operands; held until the next DONE.

Behaviour:
- Reset: rst sampled high on a rising edge forces:
  - state = IDLE
  - x = 0, y = 0, result = 0
  - busy = 0, done = 0
- Reset has priority over all other activity. Reset mid-operation aborts the computation and no done is emitted.
- Internal working registers: x, y, each WIDTH bits. All arithmetic is unsigned.
- State encoding (4-bit): IDLE 0000, CHECK 0001, SUB_A 0010, SUB_B 0011, DONE 0100. All other codes go to IDLE on the next edge.
- IDLE:
  - If start=1: x<=a, y<=b, go to CHECK.
  - Else stay in IDLE; x, y and result unchanged.
- CHECK, decided on registered x and y, in priority order:
  - x==0: result<=y, go to DONE.
  - y==0: result<=x, go to DONE.
  - x==y: result<=x, go to DONE.
  - x>y: go to SUB_A.
  - Otherwise: go to SUB_B.
- SUB_A: x<=x-y, go to CHECK.
- SUB_B: y<=y-x, go to CHECK.
- Subtraction never underflows: it only occurs when the minuend is strictly larger.
- DONE: done=1 for exactly this cycle, then go to IDLE.
- busy and done are registered, state-decoded outputs.
- start is ignored while not in IDLE, including in DONE. The earliest new accept is the cycle after DONE.
- Latency from the accepting edge to the edge that enters DONE: 2*N + 1 edges, where N is the number of subtractions. done is visible for the cycle following that edge.
- Boundary cases:
  - a=0, b=0 gives result 0 with N=0.
  - a=0 gives result b; b=0 gives result a.
  - a==b gives result a with N=0.
  - result is never cleared except by reset.
- Worst-case N = 2^WIDTH - 2 (a=1, b=max). There is no timeout.

Optional Feature:
- Macro: GCD_ITER_COUNT_EN.
- When defined:
  - Adds output iter_count, 16 bits: the number of SUB_A/SUB_B cycles in the current or last operation.
  - Cleared to 0 on reset and on the accepting edge; incremented on every SUB_A/SUB_B edge.
  - Saturates at 16'hFFFF and is held until the next accept.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- rst high for 2 cycles with start=1 -> busy=0, done=0, result=0, state IDLE after release.
- a=12, b=18, start pulse -> sequence CHECK, SUB_B, CHECK, SUB_A, CHECK, DONE; done high 6 cycles after accept; result=6; iter_count=2.
- a=1, b=5 -> 4 subtractions; done 10 cycles after accept; result=1; iter_count=4.
- a=0, b=7, then a=0, b=0 back-to-back (second start in the cycle after DONE) -> result=7, then result=0; each done 2 cycles after accept.
- a=48, b=36 with start held high throughout -> result=12; starts during busy/DONE ignored; re-accept in the first IDLE cycle after done.
- a=1, b=100, rst asserted on the 5th cycle after accept -> no done pulse, result=0, busy=0; new op a=9, b=9 -> result=9.
